// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: register-file write-back arbiter (ALU over long-latency FIFO) with pending-register scoreboard
// Ports: clk/rst_n clock and async active-low reset; alu_* single-cycle results (no backpressure);
// lsu_* long-latency results into the FIFO (lsu_ready = not full); iss_valid/iss_rd mark a register pending;
// rs1/rs2 -> rs1_busy/rs2_busy combinational pending lookups; we3/wa3/wd3 registered write port;
// fifo_count current FIFO occupancy.
module regfile_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int XLEN = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  input  logic [4:0]               alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [4:0]               lsu_rd,
  input  logic [XLEN-1:0]          lsu_data,
  input  logic                     iss_valid,
  input  logic [4:0]               iss_rd,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  output logic                     rs1_busy,
  output logic                     rs2_busy,
  output logic                     we3,
  output logic [4:0]               wa3,
  output logic [XLEN-1:0]          wd3,
  output logic [$clog2(DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(DEPTH);
  logic [4:0] mem_rd [DEPTH];
  logic [XLEN-1:0] mem_data [DEPTH];
  logic [AW-1:0] rptr, wptr;
  logic [31:0] pending, set_mask, clr_mask;
  logic push, pop;
  logic [4:0] head_rd;
  assign lsu_ready = fifo_count < (AW+1)'(DEPTH);
  assign push = lsu_valid && lsu_ready;
  assign pop = !alu_valid && fifo_count != '0;
  assign head_rd = mem_rd[rptr];
  assign set_mask = iss_valid ? 32'd1 << iss_rd : '0;
  // the clear lands on the same edge that registers the popped entry into we3
  assign clr_mask = pop ? 32'd1 << head_rd : '0;
  assign rs1_busy = pending[rs1];
  assign rs2_busy = pending[rs2];
  always_ff @(posedge clk)
    if (push) begin
      mem_rd[wptr] <= lsu_rd;
      mem_data[wptr] <= lsu_data;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rptr <= '0;
      wptr <= '0;
      fifo_count <= '0;
      pending <= '0;
      we3 <= 1'b0;
      wa3 <= '0;
      wd3 <= '0;
    end else begin
      rptr <= rptr + AW'(pop);
      wptr <= wptr + AW'(push);
      fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
      // set after clear so a same-cycle reissue keeps the register pending
      pending <= ((pending & ~clr_mask) | set_mask) & ~32'd1;
      we3 <= alu_valid ? alu_rd != 5'd0 : pop && head_rd != 5'd0;
      if (alu_valid || pop) begin
        wa3 <= alu_valid ? alu_rd : head_rd;
        wd3 <= alu_valid ? alu_data : mem_data[rptr];
      end
    end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: scoreboard bench for the write-back arbiter
module tb_regfile_wb_arbiter;
  logic clk = 1'b0, rst_n = 1'b0;
  logic alu_valid = 1'b0, lsu_valid = 1'b0, iss_valid = 1'b0;
  logic [4:0] alu_rd = '0, lsu_rd = '0, iss_rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] alu_data = '0, lsu_data = '0;
  logic lsu_ready, rs1_busy, rs2_busy, we3;
  logic [4:0] wa3;
  logic [31:0] wd3;
  logic [2:0] fifo_count;
  int n_cmp = 0, n_err = 0;
  logic [36:0] exp_q[$];
  always #5 clk = ~clk;
  regfile_wb_arbiter #(.DEPTH(4), .XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .rs1(rs1), .rs2(rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .we3(we3), .wa3(wa3), .wd3(wd3), .fifo_count(fifo_count)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] d);
    exp_q.push_back({rd, d});
  endtask
  task automatic lsu_push(input logic [4:0] rd, input logic [31:0] d);
    logic acc;
    lsu_valid = 1'b1;
    lsu_rd = rd;
    lsu_data = d;
    for (int i = 0; i < 20; i++) begin
      acc = lsu_ready;
      tick();
      if (acc) break;
      if (i == 19) chk("lsu_push_timeout", 32'd0, 32'd1);
    end
    lsu_valid = 1'b0;
  endtask
  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask
  always @(negedge clk)
    if (rst_n && we3) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_write: got x%0d=%h want no write", wa3, wd3);
      end else begin
        logic [36:0] e;
        e = exp_q.pop_front();
        if ({wa3, wd3} !== e) begin
          n_err++;
          $display("FAIL write: got x%0d=%h want x%0d=%h", wa3, wd3, e[36:32], e[31:0]);
        end
      end
    end
  initial begin
    repeat (3) tick();
    chk("rst_we3", 32'(we3), 0);
    chk("rst_wa3", 32'(wa3), 0);
    chk("rst_wd3", wd3, 0);
    chk("rst_count", 32'(fifo_count), 0);
    chk("rst_ready", 32'(lsu_ready), 1);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", 32'(lsu_ready), 1);
    chk("post_rst_busy", 32'({rs1_busy, rs2_busy}), 0);
    // ALU priority: x7 waits behind three ALU writes
    expect_wr(3, 32'h11); expect_wr(3, 32'h22); expect_wr(3, 32'h33); expect_wr(7, 32'hAAAA0007);
    alu_valid = 1; alu_rd = 3; alu_data = 32'h11;
    lsu_valid = 1; lsu_rd = 7; lsu_data = 32'hAAAA0007;
    tick();
    lsu_valid = 0; alu_data = 32'h22;
    tick();
    alu_data = 32'h33;
    tick();
    alu_valid = 0;
    chk("prio_count_held", 32'(fifo_count), 1);
    drain();
    // x0 ALU write
    alu_valid = 1; alu_rd = 0; alu_data = 32'hDEAD;
    tick();
    chk("x0_alu_we3", 32'(we3), 0);
    // full/wrap, ALU rd=0 holds the FIFO head back
    for (int i = 1; i <= 4; i++) begin
      lsu_valid = 1; lsu_rd = 5'(i); lsu_data = 32'hB0 + 32'(i);
      expect_wr(5'(i), 32'hB0 + 32'(i));
      tick();
    end
    chk("full_count", 32'(fifo_count), 4);
    chk("full_ready", 32'(lsu_ready), 0);
    lsu_rd = 5'd30; lsu_data = 32'hBAD;
    tick();
    chk("full_reject", 32'(fifo_count), 4);
    lsu_valid = 0; alu_valid = 0;
    for (int i = 5; i <= 8; i++) begin
      expect_wr(5'(i), 32'hB0 + 32'(i));
      lsu_push(5'(i), 32'hB0 + 32'(i));
    end
    drain();
    chk("wrap_empty", 32'(fifo_count), 0);
    // simultaneous push/pop at count 2
    alu_valid = 1; alu_rd = 0;
    expect_wr(10, 32'hA10); expect_wr(11, 32'hA11); expect_wr(12, 32'hA12);
    lsu_valid = 1; lsu_rd = 10; lsu_data = 32'hA10;
    tick();
    lsu_rd = 11; lsu_data = 32'hA11;
    tick();
    chk("pp_count_before", 32'(fifo_count), 2);
    alu_valid = 0; lsu_rd = 12; lsu_data = 32'hA12;
    tick();
    lsu_valid = 0;
    chk("pp_count_after", 32'(fifo_count), 2);
    drain();
    // x0 LSU entry is popped without a write
    alu_valid = 1; alu_rd = 0;
    lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h5A;
    tick();
    lsu_valid = 0;
    chk("x0_lsu_count1", 32'(fifo_count), 1);
    alu_valid = 0;
    tick();
    chk("x0_lsu_popped", 32'(fifo_count), 0);
    chk("x0_lsu_we3", 32'(we3), 0);
    iss_valid = 1; iss_rd = 0; rs1 = 0;
    tick();
    iss_valid = 0;
    chk("x0_never_busy", 32'(rs1_busy), 0);
    // scoreboard
    rs1 = 9; rs2 = 9;
    iss_valid = 1; iss_rd = 9;
    chk("sb_not_yet", 32'(rs1_busy), 0);
    tick();
    iss_valid = 0;
    chk("sb_rs1_busy", 32'(rs1_busy), 1);
    chk("sb_rs2_busy", 32'(rs2_busy), 1);
    expect_wr(9, 32'h99);
    lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h99;
    tick();
    lsu_valid = 0;
    chk("sb_busy_queued", 32'(rs1_busy), 1);
    tick();
    chk("sb_clear_wa3", {26'd0, we3, wa3}, {26'd0, 1'b1, 5'd9});
    chk("sb_cleared", 32'(rs1_busy), 0);
    iss_valid = 1; iss_rd = 9;
    tick();
    iss_valid = 0;
    expect_wr(9, 32'h98);
    lsu_valid = 1; lsu_rd = 9; lsu_data = 32'h98;
    tick();
    lsu_valid = 0;
    iss_valid = 1; iss_rd = 9;
    tick();
    iss_valid = 0;
    chk("sb_set_wins_we3", {26'd0, we3, wa3}, {26'd0, 1'b1, 5'd9});
    chk("sb_set_wins", 32'(rs1_busy), 1);
    drain();
    // reset mid-operation
    alu_valid = 1; alu_rd = 0;
    lsu_valid = 1; lsu_rd = 20; lsu_data = 32'h20;
    iss_valid = 1; iss_rd = 5; rs1 = 5;
    tick();
    lsu_rd = 21; lsu_data = 32'h21; iss_valid = 0;
    tick();
    lsu_valid = 0;
    chk("mid_count2", 32'(fifo_count), 2);
    chk("mid_busy5", 32'(rs1_busy), 1);
    #3 rst_n = 0;
    alu_valid = 0;
    #1;
    chk("mid_rst_count", 32'(fifo_count), 0);
    chk("mid_rst_busy", 32'(rs1_busy), 0);
    chk("mid_rst_ready", 32'(lsu_ready), 1);
    chk("mid_rst_we3", 32'(we3), 0);
    tick();
    rst_n = 1;
    repeat (5) tick();
    chk("post_mid_count", 32'(fifo_count), 0);
    chk("post_mid_queue", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
